// File: rtl/shot_clock_timer.sv
// Shot-clock countdown engine: two BCD digits decremented once per TICK_DIV clocks while running.
// Latency: control inputs take effect at the sampling edge; outputs are decoded from registers.
// Backpressure: none; the display strobe is free-running and the engine never stalls.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, pause, reload - level controls sampled each clock (priority reload > pause > start)
//   d1, d0              - tens / ones BCD digits for the seven-segment mux
//   scan_en             - one-cycle scan strobe every SCAN_DIV clocks
//   running             - high while counting
//   expired             - one-cycle pulse on the 01 -> 00 step
// Build option: define SHOT_CLOCK_BLANK_LEAD_EN to blank a leading zero on d1 (4'hF).
module shot_clock_timer #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int SCAN_DIV  = 100_000,
  parameter int START_VAL = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       reload,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       scan_en,
  output logic       running,
  output logic       expired
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);

  localparam logic [3:0]    START_TENS = 4'(START_VAL / 10);
  localparam logic [3:0]    START_ONES = 4'(START_VAL % 10);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [SW-1:0] SCAN_MAX   = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_ONE   = SW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    ones_q, ones_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic          expired_q, expired_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tens_q     <= START_TENS;
      ones_q     <= START_ONES;
      presc_q    <= '0;
      scan_cnt_q <= '0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      presc_q    <= presc_d;
      scan_cnt_q <= scan_cnt_d;
      expired_q  <= expired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    presc_d   = presc_q;
    expired_d = 1'b0;

    if (reload) begin
      // Reload overrides everything, including a decrement due this edge.
      state_d = IDLE;
      tens_d  = START_TENS;
      ones_d  = START_ONES;
      presc_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!pause && start) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (pause) begin
            // Pause wins over a due decrement; prescaler keeps its phase.
            state_d = PAUSE;
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
            end
            if (tens_q == 4'd0 && ones_q == 4'd1) begin
              state_d   = EXPIRED;
              expired_d = 1'b1;
            end
          end else begin
            presc_d = presc_q + PRESC_ONE;
          end
        end
        PAUSE: begin
          // Resume edge does not advance the prescaler.
          if (!pause && start) begin
            state_d = RUN;
          end
        end
        default: begin
          // EXPIRED: only reload leaves this state.
          state_d = EXPIRED;
        end
      endcase
    end
  end

  // Free-running display scan divider, independent of the count state.
  always_comb begin
    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = '0;
    end else begin
      scan_cnt_d = scan_cnt_q + SCAN_ONE;
    end
  end

  assign scan_en = (scan_cnt_q == SCAN_MAX);
  assign running = (state_q == RUN);
  assign expired = expired_q;
  assign d0      = ones_q;

`ifdef SHOT_CLOCK_BLANK_LEAD_EN
  assign d1 = (tens_q == 4'd0) ? 4'hF : tens_q;
`else
  assign d1 = tens_q;
`endif

endmodule

// File: tb/tb_shot_clock_timer.sv
// Bench for shot_clock_timer: scripted scenarios plus randomized control levels,
// with an integer-valued reference model compared against the outputs every cycle.
// Small parameters (TICK_DIV=10, SCAN_DIV=4, START_VAL=12) keep runs short.
module tb_shot_clock_timer;

  localparam int TICK  = 10;
  localparam int SCAN  = 4;
  localparam int STARTV = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       reload = 1'b0;
  logic [3:0] d1, d0;
  logic       scan_en, running, expired;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  shot_clock_timer #(
    .TICK_DIV (TICK),
    .SCAN_DIV (SCAN),
    .START_VAL(STARTV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pause  (pause),
    .reload (reload),
    .d1     (d1),
    .d0     (d0),
    .scan_en(scan_en),
    .running(running),
    .expired(expired)
  );

  always #5 clk = ~clk;

  // Reference model: count as a plain integer, mode as a small integer,
  // phase = clocks spent running since the last decrement.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
  int m_val   = STARTV;
  int m_phase = 0;
  int m_mode  = M_IDLE;
  int m_exp   = 0;
  int m_edges = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_val = STARTV; m_phase = 0; m_mode = M_IDLE; m_exp = 0; m_edges = 0;
    end else begin
      m_edges = m_edges + 1;
      m_exp = 0;
      if (reload) begin
        m_val = STARTV; m_phase = 0; m_mode = M_IDLE;
      end else if (m_mode == M_RUN) begin
        if (pause) m_mode = M_PAUSE;
        else begin
          m_phase = m_phase + 1;
          if (m_phase == TICK) begin
            m_phase = 0;
            m_val = m_val - 1;
            if (m_val == 0) begin m_mode = M_EXP; m_exp = 1; end
          end
        end
      end else if (m_mode == M_IDLE && !pause && start) begin
        m_mode = M_RUN; m_phase = 0;
      end else if (m_mode == M_PAUSE && !pause && start) begin
        m_mode = M_RUN;
      end
    end
  end

  function automatic int exp_d1(input int tens);
`ifdef SHOT_CLOCK_BLANK_LEAD_EN
    return (tens == 0) ? 15 : tens;
`else
    return tens;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s at %0t: actual %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("cyc_d1", int'(d1), exp_d1(m_val / 10));
      check("cyc_d0", int'(d0), m_val % 10);
      check("cyc_running", int'(running), (m_mode == M_RUN) ? 1 : 0);
      check("cyc_expired", int'(expired), m_exp);
      check("cyc_scan_en", int'(scan_en), ((m_edges % SCAN) == SCAN - 1) ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_count(input string name, input int tens, input int ones);
    check({name, "_d1"}, int'(d1), exp_d1(tens));
    check({name, "_d0"}, int'(d0), ones);
  endtask

  int scan_pat [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
  int r;

  initial begin
    // Reset and release between edges (at a falling edge).
    cyc(3);
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check_count("rst_val", 1, 2);
    check("rst_running", int'(running), 0);
    check("rst_expired", int'(expired), 0);
    check("rst_scan_en", int'(scan_en), 0);
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      check("scan_pattern", int'(scan_en), scan_pat[k]);
    end

    // Single-cycle start pulse: 11 after 10 clocks, 09 after 30 clocks.
    start = 1'b1; cyc(1); start = 1'b0;
    check("start_running", int'(running), 1);
    cyc(9);
    check_count("pre_first_dec", 1, 2);
    cyc(1);
    check_count("first_dec", 1, 1);
    check("model_val_11", m_val, 11);
    cyc(20);
    check_count("count_09", 0, 9);

    // Pause after 13 running clocks, hold 50, resume: next decrement 7 clocks later.
    reload = 1'b1; cyc(1); reload = 1'b0;
    check_count("reload_12", 1, 2);
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(13);
    pause = 1'b1;
    cyc(50);
    check_count("paused_11", 1, 1);
    check("paused_running", int'(running), 0);
    pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
    cyc(6);
    check_count("resume_pre", 1, 1);
    cyc(1);
    check_count("resume_dec_10", 1, 0);

    // Run to completion: 10 more decrements of 10 clocks.
    cyc(99);
    check_count("count_01", 0, 1);
    check("pre_exp_pulse", int'(expired), 0);
    cyc(1);
    check_count("count_00", 0, 0);
    check("exp_pulse", int'(expired), 1);
    check("exp_running", int'(running), 0);
    check("model_exp", m_exp, 1);
    cyc(1);
    check("exp_pulse_end", int'(expired), 0);
    start = 1'b1; cyc(20); start = 1'b0;
    check_count("exp_hold", 0, 0);
    check("exp_hold_running", int'(running), 0);

    // Reload together with start at count 07.
    reload = 1'b1; cyc(1); reload = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(50);
    check_count("count_07", 0, 7);
    cyc(4);
    reload = 1'b1; start = 1'b1; cyc(1); reload = 1'b0; start = 1'b0;
    check_count("reload_start", 1, 2);
    check("reload_start_running", int'(running), 0);
    check("reload_start_expired", int'(expired), 0);

    // Pause sampled on the edge a decrement is due.
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(9);
    pause = 1'b1; cyc(1);
    check_count("pause_due", 1, 2);
    cyc(3);
    pause = 1'b0; start = 1'b1; cyc(1); start = 1'b0;
    check_count("pause_resume", 1, 2);
    check("pause_resume_running", int'(running), 1);
    cyc(1);
    check_count("pause_resume_dec", 1, 1);

    // Asynchronous reset mid-run: outputs revert without a clock edge.
    cyc(13);
    #2 rst = 1'b1;
    #1;
    check_count("async_rst", 1, 2);
    check("async_rst_running", int'(running), 0);
    check("async_rst_expired", int'(expired), 0);
    check("async_rst_scan_en", int'(scan_en), 0);
    cyc(2);
    rst = 1'b0;

    // Randomized control levels; reload kept rare so expiry is reached.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      reload = ($urandom_range(0, 399) == 0);
      pause  = (r < 6);
      start  = ($urandom_range(0, 3) == 0);
      if (i % 700 == 699) reload = 1'b1;
      cyc(1);
    end
    reload = 1'b0; pause = 1'b0; start = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
